// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer: note ROM word layout,
// FSM state encoding and tempo codes.
package song_sequencer_pkg;

  // Note ROM word layout
  localparam int ROM_W     = 16;
  localparam int END_BIT   = 15;
  localparam int REST_BIT  = 14;
  localparam int LEN_LSB   = 11;
  localparam int LEN_W     = 3;
  localparam int PITCH_LSB = 0;
  localparam int PITCH_W   = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_PLAY   = 2'd3
  } state_e;

  // Tempo codes; any code with bit 1 set selects the quarter-length beat
  localparam logic [1:0] TEMPO_X1 = 2'b00;
  localparam logic [1:0] TEMPO_X2 = 2'b01;

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Beat timer: counts ticks 0..last while enabled and flags the final tick
// of each beat. A load clears the count so every note starts on a fresh beat.
module song_sequencer_beat_timer
  import song_sequencer_pkg::*;
#(
  parameter int TICK_W = 3
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              en,
  input  logic [TICK_W-1:0] last,
  output logic              beat
);

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;

  // Beat fires on the last tick of the period, only while counting
  assign beat = en && (tick_q == last);

  // Next tick: clear on load, wrap at end of beat, hold while disabled
  always_comb begin
    tick_d = tick_q;
    if (load) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = beat ? '0 : tick_q + 1'b1;
    end
  end

  // Tick register
  always_ff @(posedge clk) begin
    if (srst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the note ROM, times each note in beats at the
// tempo captured when the note is decoded, and gates the tone generator.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int BEAT_TICKS = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        tempo,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [7:0]        note_code,
  output logic              note_valid,
  output logic              note_start,
  output logic              busy,
  output logic              done
);

  // Tick counter only needs to reach BEAT_TICKS-1; shorter tempos floor
  localparam int TICK_W = $clog2(BEAT_TICKS);
  localparam logic [TICK_W-1:0] LAST_X1 = TICK_W'(BEAT_TICKS - 1);
  localparam logic [TICK_W-1:0] LAST_X2 = TICK_W'((BEAT_TICKS >> 1) - 1);
  localparam logic [TICK_W-1:0] LAST_X4 = TICK_W'((BEAT_TICKS >> 2) - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PITCH_W-1:0]  code_q, code_d;
  logic                valid_q, valid_d;
  logic                nstart_q, nstart_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    beats_q, beats_d;
  logic                sound_q, sound_d;
  logic [TICK_W-1:0]   last_q, last_d;

  logic                w_end;
  logic                w_rest;
  logic [LEN_W-1:0]    w_len;
  logic [PITCH_W-1:0]  w_pitch;
  logic                unused_rom_bits;
  logic [TICK_W-1:0]   last_sel;
  logic                timer_load;
  logic                timer_en;
  logic                beat;
  logic                note_over;

  assign w_end           = rom_data[END_BIT];
  assign w_rest          = rom_data[REST_BIT];
  assign w_len           = rom_data[LEN_LSB +: LEN_W];
  assign w_pitch         = rom_data[PITCH_LSB +: PITCH_W];
  assign unused_rom_bits = ^rom_data[10:8];

  // The timer is cleared while decoding and only counts in PLAY with pause low
  assign timer_load = (state_q == ST_DECODE);
  assign timer_en   = (state_q == ST_PLAY) && !pause;
  assign note_over  = beat && (beats_q == '0);

  song_sequencer_beat_timer #(
    .TICK_W(TICK_W)
  ) u_beat_timer (
    .clk  (CLOCK_50),
    .srst (reset),
    .load (timer_load),
    .en   (timer_en),
    .last (last_q),
    .beat (beat)
  );

  // Map tempo code to the last tick index of a beat
  always_comb begin
    last_sel = LAST_X4;
    if (tempo == TEMPO_X1) begin
      last_sel = LAST_X1;
    end else if (tempo == TEMPO_X2) begin
      last_sel = LAST_X2;
    end
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop aborts from anywhere
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_FETCH;
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          if (w_end) begin
            state_d = (loop_en && (addr_q != '0)) ? ST_FETCH : ST_IDLE;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_PLAY:   if (note_over) state_d = (&addr_q) ? ST_IDLE : ST_FETCH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values; pulses and gate default low
  always_comb begin
    addr_d   = addr_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    nstart_d = 1'b0;
    done_d   = 1'b0;
    beats_d  = beats_q;
    sound_d  = sound_q;
    last_d   = last_q;
    busy_d   = (state_d != ST_IDLE);
    if (!stop) begin
      case (state_q)
        ST_IDLE: begin
          if (start) addr_d = '0;
        end
        ST_DECODE: begin
          if (w_end) begin
            if (loop_en && (addr_q != '0)) begin
              addr_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            code_d   = w_pitch;
            last_d   = last_sel;
            beats_d  = w_len;
            sound_d  = !w_rest;
            valid_d  = !w_rest && !pause;
            nstart_d = !w_rest;
          end
        end
        ST_PLAY: begin
          valid_d = sound_q && !pause;
          if (beat) begin
            if (beats_q == '0) begin
              valid_d = 1'b0;
              if (&addr_q) begin
                done_d = 1'b1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end else begin
              beats_d = beats_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      addr_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      nstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      beats_q  <= '0;
      sound_q  <= 1'b0;
      last_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      nstart_q <= nstart_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      beats_q  <= beats_d;
      sound_q  <= sound_d;
      last_q   <= last_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_code  = code_q;
  assign note_valid = valid_q;
  assign note_start = nstart_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: directed songs from the spec plus random
// songs, checked cycle by cycle against a note-timeline reference model.
module tb_song_sequencer;

  localparam int ADDR_W     = 4;
  localparam int BEAT_TICKS = 8;
  localparam int MAXC       = 2048;
  localparam int NONE       = 1_000_000;

  logic              clk = 1'b0;
  logic              reset, start, stop, pause, loop_en;
  logic [1:0]        tempo;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [7:0]        note_code;
  logic              note_valid, note_start, busy, done;

  logic [15:0] rom_mem [16];

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  song_sequencer #(
    .ADDR_W     (ADDR_W),
    .BEAT_TICKS (BEAT_TICKS)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .tempo      (tempo),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_code  (note_code),
    .note_valid (note_valid),
    .note_start (note_start),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Per-cycle stimulus and expected trace (index = cycle after start)
  bit         pause_v [MAXC];
  logic [1:0] tempo_v [MAXC];
  bit         loop_v;
  bit         exp_busy [MAXC];
  bit         exp_done [MAXC];
  bit         exp_valid [MAXC];
  bit         exp_nstart [MAXC];
  bit         chk_code [MAXC];
  int         exp_addr [MAXC];
  int         exp_code [MAXC];
  int         cur_addr;
  int         run_no = 0;

  function automatic int period_of(input logic [1:0] t);
    if (t == 2'b00) return BEAT_TICKS;
    if (t == 2'b01) return BEAT_TICKS / 2;
    return BEAT_TICKS / 4;
  endfunction

  // Timeline model: each ROM word costs a fetch and a decode cycle, then a
  // note occupies (len+1)*period un-paused play cycles.
  task automatic build_model(input int stop_at, input int rst_at, output int run_len);
    int c, a, need, fin, cut;
    bit first, snd;
    logic [15:0] w;
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_valid[i] = 0; exp_nstart[i] = 0;
      chk_code[i] = 0; exp_addr[i] = 0; exp_code[i] = 0;
    end
    exp_addr[0] = cur_addr;
    c = 1; a = 0; fin = -1;
    while (fin < 0 && c < MAXC - 80) begin
      w = rom_mem[a];
      exp_busy[c] = 1;     exp_addr[c] = a;
      exp_busy[c + 1] = 1; exp_addr[c + 1] = a;
      if (w[15]) begin
        if (loop_v && a != 0) begin
          a = 0; c += 2;
        end else begin
          fin = c + 2; exp_done[fin] = 1;
        end
      end else begin
        need  = (int'(w[13:11]) + 1) * period_of(tempo_v[c + 1]);
        snd   = !w[14];
        first = 1;
        c += 2;
        while (need > 0 && c < MAXC - 80) begin
          exp_busy[c] = 1; exp_addr[c] = a;
          exp_valid[c]  = snd && !pause_v[c - 1];
          exp_nstart[c] = first && snd;
          exp_code[c]   = int'(w[7:0]);
          chk_code[c]   = 1;
          if (!pause_v[c]) need--;
          c++; first = 0;
        end
        if (a == 15) begin
          fin = c; exp_done[fin] = 1;
        end else begin
          a++;
        end
      end
    end
    if (fin < 0) fin = c;
    for (int i = fin; i < MAXC; i++) exp_addr[i] = a;
    cut = (stop_at < rst_at) ? stop_at : rst_at;
    if (cut < MAXC - 1) begin
      for (int i = cut + 1; i < MAXC; i++) begin
        exp_busy[i] = 0; exp_done[i] = 0; exp_valid[i] = 0; exp_nstart[i] = 0;
        if (rst_at < stop_at) begin
          exp_addr[i] = 0; exp_code[i] = 0; chk_code[i] = 1;
        end else begin
          exp_addr[i] = exp_addr[cut]; chk_code[i] = 0;
        end
      end
      if (cut + 1 < fin) fin = cut + 1;
    end
    run_len = fin + 3;
    if (run_len > MAXC - 1) run_len = MAXC - 1;
  endtask

  task automatic run(input int stop_at, input int rst_at);
    int len;
    build_model(stop_at, rst_at, len);
    run_no++;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check_val($sformatf("r%0d c%0d busy", run_no, c), busy, exp_busy[c]);
        check_val($sformatf("r%0d c%0d done", run_no, c), done, exp_done[c]);
        check_val($sformatf("r%0d c%0d note_valid", run_no, c), note_valid, exp_valid[c]);
        check_val($sformatf("r%0d c%0d note_start", run_no, c), note_start, exp_nstart[c]);
        check_val($sformatf("r%0d c%0d rom_addr", run_no, c), rom_addr, exp_addr[c]);
        if (chk_code[c])
          check_val($sformatf("r%0d c%0d note_code", run_no, c), note_code, exp_code[c]);
      end
      start   = (c == 0);
      stop    = (c == stop_at);
      reset   = (c == rst_at);
      pause   = pause_v[c];
      tempo   = tempo_v[c];
      loop_en = loop_v;
    end
    start = 0; stop = 0; reset = 0; pause = 0;
    cur_addr = exp_addr[len];
    $display("run %0d: %0d cycles, stop_at=%0d rst_at=%0d loop=%0d", run_no, len, stop_at, rst_at, loop_v);
  endtask

  task automatic quiet(input logic [1:0] t);
    for (int i = 0; i < MAXC; i++) begin
      tempo_v[i] = t; pause_v[i] = 0;
    end
  endtask

  task automatic set_song(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h8000;
    rom_mem[0] = w0; rom_mem[1] = w1; rom_mem[2] = w2;
  endtask

  task automatic random_run();
    int n, stop_at, rst_at;
    logic [15:0] w;
    bit pz;
    n = ($urandom_range(0, 5) == 0) ? 16 : $urandom_range(0, 8);
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      if (i < n) begin
        w[15] = 1'b0;
        if ($urandom_range(0, 3) != 0) w[14] = 1'b0;
        w[13:11] = 3'($urandom_range(0, 3));
      end else begin
        w[15] = 1'b1;
      end
      rom_mem[i] = w;
    end
    pz = ($urandom_range(0, 1) == 1);
    tempo_v[0] = 2'($urandom_range(0, 3));
    for (int i = 0; i < MAXC; i++) begin
      if (i > 0) tempo_v[i] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : tempo_v[i - 1];
      pause_v[i] = pz && ($urandom_range(0, 7) == 0);
    end
    loop_v  = ($urandom_range(0, 2) == 0);
    stop_at = NONE;
    rst_at  = NONE;
    if (loop_v) stop_at = $urandom_range(30, 500);
    else if ($urandom_range(0, 4) == 0) stop_at = $urandom_range(1, 200);
    else if ($urandom_range(0, 6) == 0) rst_at = $urandom_range(3, 150);
    run(stop_at, rst_at);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 1; stop = 0; pause = 0; loop_en = 0; tempo = 2'b00;
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h8000;
    // Reset held 3 cycles with start high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("reset%0d busy", i), busy, 0);
      check_val($sformatf("reset%0d done", i), done, 0);
      check_val($sformatf("reset%0d note_valid", i), note_valid, 0);
      check_val($sformatf("reset%0d note_start", i), note_start, 0);
      check_val($sformatf("reset%0d rom_addr", i), rom_addr, 0);
      check_val($sformatf("reset%0d note_code", i), note_code, 0);
    end
    reset = 0; start = 0; cur_addr = 0; loop_v = 0;

    // Spec song at each tempo
    set_song(16'h003C, 16'h1040, 16'h8000);
    quiet(2'b00); run(NONE, NONE);
    quiet(2'b01); run(NONE, NONE);
    quiet(2'b11); run(NONE, NONE);
    // Tempo change mid-note only affects the next note
    quiet(2'b00);
    for (int i = 5; i < MAXC; i++) tempo_v[i] = 2'b11;
    run(NONE, NONE);
    // Rest then note
    set_song(16'h4800, 16'h003C, 16'h8000);
    quiet(2'b00); run(NONE, NONE);
    // Pause 5 cycles in the middle of the first note
    set_song(16'h003C, 16'h1040, 16'h8000);
    quiet(2'b00);
    for (int i = 5; i < 10; i++) pause_v[i] = 1;
    run(NONE, NONE);
    // Stop mid-note, start+stop together, reset mid-note
    quiet(2'b00); run(6, NONE);
    run(0, NONE);
    run(NONE, 7);
    // Looping song stopped later; END at address 0 with loop finishes
    loop_v = 1; run(100, NONE);
    set_song(16'h8000, 16'h8000, 16'h8000);
    run(NONE, NONE);
    loop_v = 0;
    // Full ROM without END: finishes at the last address, no wrap
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0000 | 16'(8'h50 + i);
    quiet(2'b11); run(NONE, NONE);
    // Random songs
    for (int k = 0; k < 24; k++) random_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
